// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default qualification time for input debouncers
package debounce_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b11,
    WAIT_LOW  = 2'b10
  } state_t;
  localparam int DEFAULT_STABLE_CYCLES = 50000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with async active-low reset to a selectable level
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises and filters a bouncing button into a clean level plus press/release pulses
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic s;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic level_n, press_n, release_n;
  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ACTIVE_LOW ? ~btn_raw : btn_raw),
    .q    (s)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE_LOW;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      btn_level   <= level_n;
      btn_press   <= press_n;
      btn_release <= release_n;
    end
  end
  // Any sample disagreeing with the candidate level drops back to idle and discards the count
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE_LOW: if (s) begin
        state_n = WAIT_HIGH;
        cnt_n   = CW'(1);
      end
      WAIT_HIGH: if (!s) begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
      end else if (cnt == LAST) begin
        state_n = IDLE_HIGH;
        cnt_n   = '0;
        level_n = 1'b1;
        press_n = 1'b1;
      end else cnt_n = cnt + CW'(1);
      IDLE_HIGH: if (!s) begin
        state_n = WAIT_LOW;
        cnt_n   = CW'(1);
      end
      WAIT_LOW: if (s) begin
        state_n = IDLE_HIGH;
        cnt_n   = '0;
      end else if (cnt == LAST) begin
        state_n   = IDLE_LOW;
        cnt_n     = '0;
        level_n   = 1'b0;
        release_n = 1'b1;
      end else cnt_n = cnt + CW'(1);
    endcase
  end
endmodule
